// File: rtl/vga_timing_gen_if.sv
// Raster position/sync bundle from the timing generator to renderers and DAC pins.
// VGA_FRAME_CNT_EN adds the frame_start / frame_count signals.
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
`ifdef VGA_FRAME_CNT_EN
  logic        frame_start;
  logic [15:0] frame_count;
  modport master (output DrawX, DrawY, blank, hs, vs, frame_start, frame_count);
  modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start, frame_count);
`else
  modport master (output DrawX, DrawY, blank, hs, vs);
  modport slave  (input  DrawX, DrawY, blank, hs, vs);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: undelayed DrawX/DrawY, hs/vs/blank delayed PIPE_DLY clk.
// Optional frame_start/frame_count under `define VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIPE_DLY  = 2,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic             vga_clk,
  input  logic             Reset,
  vga_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  logic [9:0] r_hc, r_vc;
  logic       w_h_end, w_v_end;
  logic       w_hs_lvl, w_vs_lvl, w_blank_raw;

  assign w_h_end = (r_hc == 10'(H_TOTAL - 1));
  assign w_v_end = (r_vc == 10'(V_TOTAL - 1));

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_h_end) begin
      r_hc <= '0;
      r_vc <= w_v_end ? '0 : r_vc + 10'd1;
    end else begin
      r_hc <= r_hc + 10'd1;
    end
  end

  assign w_hs_lvl = ((r_hc >= 10'(H_VISIBLE + H_FP)) &&
                     (r_hc <  10'(H_VISIBLE + H_FP + H_SYNC))) ? SYNC_POL : ~SYNC_POL;
  assign w_vs_lvl = ((r_vc >= 10'(V_VISIBLE + V_FP)) &&
                     (r_vc <  10'(V_VISIBLE + V_FP + V_SYNC))) ? SYNC_POL : ~SYNC_POL;
  assign w_blank_raw = (r_hc < 10'(H_VISIBLE)) && (r_vc < 10'(V_VISIBLE));

  // Stage 0 takes the raw terms; the last stage drives the pins.
  logic [PIPE_DLY-1:0] r_hs_pipe, r_vs_pipe, r_blank_pipe;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_hs_pipe    <= {PIPE_DLY{~SYNC_POL}};
      r_vs_pipe    <= {PIPE_DLY{~SYNC_POL}};
      r_blank_pipe <= '0;
    end else begin
      r_hs_pipe[0]    <= w_hs_lvl;
      r_vs_pipe[0]    <= w_vs_lvl;
      r_blank_pipe[0] <= w_blank_raw;
      for (int i = 1; i < PIPE_DLY; i++) begin
        r_hs_pipe[i]    <= r_hs_pipe[i-1];
        r_vs_pipe[i]    <= r_vs_pipe[i-1];
        r_blank_pipe[i] <= r_blank_pipe[i-1];
      end
    end
  end

  assign vif.DrawX = r_hc;
  assign vif.DrawY = r_vc;
  assign vif.hs    = r_hs_pipe[PIPE_DLY-1];
  assign vif.vs    = r_vs_pipe[PIPE_DLY-1];
  assign vif.blank = r_blank_pipe[PIPE_DLY-1];

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge vga_clk) begin
    if (Reset)
      r_frame_cnt <= '0;
    else if (w_h_end && w_v_end)
      r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  // Masked by Reset so the held-at-origin counters don't pulse during reset.
  assign vif.frame_start = (r_hc == '0) && (r_vc == '0) && !Reset;
  assign vif.frame_count = r_frame_cnt;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small-geometry instances (PIPE_DLY=2/active-low, PIPE_DLY=1/active-high)
// plus a default 640x480 instance for one full-width line.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if a ();
  vga_timing_gen_if b ();
  vga_timing_gen_if c ();

  // Small geometry: H_TOTAL=32 (hs raw 20..25), V_TOTAL=13 (vs raw 8..9), frame 416 clk.
  vga_timing_gen #(.H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                   .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
                   .PIPE_DLY(2), .SYNC_POL(1'b0))
    u0 (.vga_clk(clk), .Reset(rst), .vif(a));
  vga_timing_gen #(.H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                   .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
                   .PIPE_DLY(1), .SYNC_POL(1'b1))
    u1 (.vga_clk(clk), .Reset(rst), .vif(b));
  vga_timing_gen u2 (.vga_clk(clk), .Reset(rst), .vif(c));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to(input int x, input int y);
    int k;
    k = 0;
    while (!(32'(a.DrawX) == x && 32'(a.DrawY) == y) && k < 2000) begin
      step();
      k++;
    end
    chk("reach_pos", 32'(k < 2000), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_lo, hs_hi_b, vs_lo, flen;

    // Reset held 3 clk
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_drawx", 32'(a.DrawX), 0);
    chk("rst_drawy", 32'(a.DrawY), 0);
    chk("rst_hs", 32'(a.hs), 1);
    chk("rst_vs", 32'(a.vs), 1);
    chk("rst_blank", 32'(a.blank), 0);
    chk("rst_hs_pol1", 32'(b.hs), 0);
    chk("rst_blank_p1", 32'(b.blank), 0);
`ifdef VGA_FRAME_CNT_EN
    chk("rst_fstart", 32'(a.frame_start), 0);
    chk("rst_fcount", 32'(a.frame_count), 0);
`endif
    rst = 1'b0;
    #1;
`ifdef VGA_FRAME_CNT_EN
    chk("rel_fstart", 32'(a.frame_start), 1);
`endif
    step();
    chk("rel_drawx1", 32'(a.DrawX), 1);
    chk("rel_blank_d2_early", 32'(a.blank), 0);
    chk("rel_blank_d1", 32'(b.blank), 1);
    step();
    chk("rel_drawx2", 32'(a.DrawX), 2);
    chk("rel_blank_d2", 32'(a.blank), 1);

    // Full 640x480 line on the default instance
    hs_lo = 0;
    for (int i = 0; i < 800; i++) begin
      step();
      if (c.hs == 1'b0) hs_lo++;
      case (32'(c.DrawX))
        0:   chk("def_wrap_y", 32'(c.DrawY), 1);
        641: chk("def_blank_639", 32'(c.blank), 1);
        642: chk("def_blank_640", 32'(c.blank), 0);
        657: chk("def_hs_pre", 32'(c.hs), 1);
        658: chk("def_hs_fall", 32'(c.hs), 0);
        753: chk("def_hs_last", 32'(c.hs), 0);
        754: chk("def_hs_rise", 32'(c.hs), 1);
        default: ;
      endcase
    end
    chk("def_hs_width", 32'(hs_lo), 96);

    // Reset mid-frame while both syncs are active
    run_to(23, 9);
    chk("pre_rst_hs", 32'(a.hs), 0);
    chk("pre_rst_vs", 32'(a.vs), 0);
    rst = 1'b1;
    step();
    chk("mid_rst_drawx", 32'(a.DrawX), 0);
    chk("mid_rst_drawy", 32'(a.DrawY), 0);
    chk("mid_rst_hs", 32'(a.hs), 1);
    chk("mid_rst_vs", 32'(a.vs), 1);
    chk("mid_rst_blank", 32'(a.blank), 0);
    chk("mid_rst_hs_p1", 32'(b.hs), 0);
    chk("mid_rst_vs_p1", 32'(b.vs), 0);
`ifdef VGA_FRAME_CNT_EN
    chk("mid_rst_fstart", 32'(a.frame_start), 0);
`endif
    rst = 1'b0;
    step();
    chk("mid_rel_blank1", 32'(a.blank), 0);
    step();
    chk("mid_rel_drawx", 32'(a.DrawX), 2);
    chk("mid_rel_blank2", 32'(a.blank), 1);

    // Blank / hs edges on small geometry, both pipe depths and polarities
    run_to(17, 0);
    chk("blank_15", 32'(a.blank), 1);
    chk("blank_p1_16", 32'(b.blank), 0);
    step();
    chk("blank_16", 32'(a.blank), 0);
    run_to(20, 0);
    chk("hs_p1_19", 32'(b.hs), 0);
    step();
    chk("hs_19", 32'(a.hs), 1);
    chk("hs_p1_20", 32'(b.hs), 1);
    step();
    chk("hs_20", 32'(a.hs), 0);
    run_to(26, 0);
    chk("hs_p1_25", 32'(b.hs), 1);
    step();
    chk("hs_25", 32'(a.hs), 0);
    chk("hs_p1_26", 32'(b.hs), 0);
    step();
    chk("hs_26", 32'(a.hs), 1);

    hs_lo = 0;
    hs_hi_b = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (a.hs == 1'b0) hs_lo++;
      if (b.hs == 1'b1) hs_hi_b++;
    end
    chk("hs_width", 32'(hs_lo), 6);
    chk("hs_width_p1", 32'(hs_hi_b), 6);
    chk("line_adv", 32'(a.DrawY), 1);

    run_to(31, 1);
    step();
    chk("hwrap_x", 32'(a.DrawX), 0);
    chk("hwrap_y", 32'(a.DrawY), 2);

    // vs start: raw at (0,8), seen PIPE_DLY clk later
    run_to(1, 8);
    chk("vs_pre", 32'(a.vs), 1);
    chk("vs_p1_start", 32'(b.vs), 1);
    step();
    chk("vs_start", 32'(a.vs), 0);

    // Whole frame: length and vs width
    run_to(0, 0);
`ifdef VGA_FRAME_CNT_EN
    chk("fcount_1", 32'(a.frame_count), 1);
`endif
    flen = 0;
    vs_lo = 0;
    do begin
      step();
      flen++;
      if (a.vs == 1'b0) vs_lo++;
    end while (!(a.DrawX == 10'd0 && a.DrawY == 10'd0) && flen < 2000);
    chk("frame_len", 32'(flen), 416);
    chk("vs_width", 32'(vs_lo), 64);
`ifdef VGA_FRAME_CNT_EN
    chk("fstart_wrap", 32'(a.frame_start), 1);
    chk("fcount_2", 32'(a.frame_count), 2);
    step();
    chk("fstart_pulse_end", 32'(a.frame_start), 0);
    force u0.r_frame_cnt = 16'hFFFF;
    step();
    release u0.r_frame_cnt;
    #1;
    chk("fcount_forced", 32'(a.frame_count), 32'hFFFF);
    run_to(0, 0);
    chk("fcount_rollover", 32'(a.frame_count), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
